if_id_elastic: RTL and testbench
================================

Name: if_id_elastic

Overview:
- Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between fetch and decode.
- Splits the fetched instruction word into ctrl, rs1, rs2, rd and constant fields, and carries the PC alongside them.
- Adds over the plain stage register: backpressure without combinational ready paths, flush-with-bubble, and a saturating count of squashed instructions.

Parameters:
- PC_W, 8, program counter width
- CTRL_W, 4, opcode/control field width
- REG_W, 3, register index width
- CONST_W, 8, immediate field width
- INS_W, CTRL_W+3*REG_W+CONST_W (21), instruction width; derived, not overridable
- NOP_CTRL, 4'b1010, control value presented for a bubble
- CNT_W, 8, squash counter width

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, synchronous active-low reset
- in_valid, input, 1, fetch presents an instruction
- in_ready, output, 1, stage can accept; registered
- in_pc, input, PC_W, next PC paired with in_ins
- in_ins, input, INS_W, instruction word
- stall, input, 1, hazard stall from decode; freezes output
- flush, input, 1, branch/jump squash
- out_valid, output, 1, head entry valid
- out_ready, input, 1, decode consumes head
- out_pc, output, PC_W, head PC
- out_ctrl, output, CTRL_W, in_ins[INS_W-1 -: CTRL_W]
- out_rs1, output, REG_W, next REG_W bits below ctrl
- out_rs2, output, REG_W, next REG_W bits below rs1
- out_rd, output, REG_W, next REG_W bits below rs2
- out_const, output, CONST_W, in_ins[CONST_W-1:0]
- squash_cnt, output, CNT_W, number of valid entries discarded by flush; saturating

Behaviour:
- Storage:
  - head entry: drives the outputs directly from flops.
  - skid entry: holds an instruction accepted while the head could not drain.
  - Occupancy is 0, 1 or 2; the state is {head_v, skid_v}, and skid_v=1 implies head_v=1.
- Handshakes:
  - Effective drain: deq = out_valid & out_ready & ~stall.
  - Accept: enq = in_valid & in_ready.
  - in_ready = ~skid_v, registered and computed from the next state.
- Transitions, when flush=0:
  - enq & ~deq: fill head if empty, otherwise fill skid.
  - deq & ~enq: skid moves to head, or head empties.
  - enq & deq: if the skid is valid it moves to head and the new entry goes to skid; otherwise the new entry goes to head.
- Latency: one cycle from accept to out_valid when empty; zero bubbles at full throughput.
- Empty head:
  - out_valid=0, out_ctrl=NOP_CTRL, all other fields and out_pc are 0.
  - The skid entry is never visible on the outputs.
- stall=1: head and skid are held; out_ready is ignored; an accept into the skid is still allowed if skid_v=0.
- flush=1:
  - Has priority over stall, enq and deq.
  - Next cycle both entries are invalid, outputs show the bubble value, and in_ready=1.
  - An instruction presented in the flush cycle is dropped and not counted.
  - squash_cnt += head_v + skid_v, saturating at all-ones with no wrap.
- Reset (rst_n=0 at a clock edge):
  - head_v=0, skid_v=0, in_ready=1, bubble outputs, squash_cnt=0.
  - Reset mid-transfer discards everything and is not counted.
- Field slicing is pure bit selection with no sign extension; out_pc is passed through unchanged.

Decomposition:
- Shared package (pipe_pkg): the field-width constants, NOP_CTRL, and the field-offset localparams derived from them, so decode and hazard units slice identically.
- One natural sub-module: skid_buf, a generic 2-entry valid/ready buffer of width PC_W+INS_W carrying the handshake and flush logic.
- The top level adds the field split, the bubble muxing and squash_cnt.

Test Plan:
- Reset, then stream in_pc=1..4 with in_ins=21'h1A5_3C3 and out_ready=1 -> out_valid one cycle later; one instruction per cycle; out_ctrl=4'hD, out_rs1=3'h1, out_rs2=3'h2, out_rd=3'h3, out_const=8'hC3; in_ready stays 1.
- Hold out_ready=0 while pushing 3 instructions -> the first two are accepted, in_ready=0 after the second, and the third is held at the input. Raise out_ready -> all drain in order with no loss or duplicate.
- Occupancy 2, then stall=1 with out_ready=1 for 3 cycles -> outputs frozen and no deq. Drop stall -> the head drains on the next edge.
- Occupancy 2 with stall=1 and flush=1 asserted together -> next cycle out_valid=0, out_ctrl=4'b1010, other fields 0, in_ready=1, squash_cnt=2.
- Repeated flushes at occupancy 2 with CNT_W=2 -> squash_cnt goes 2, 3, 3; it saturates and does not wrap.
- Reset asserted mid-stream at occupancy 1 with in_valid=1 -> all outputs return to reset values and the presented instruction is not accepted.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared IF/ID field geometry and default widths, so fetch, decode and hazard
// logic all slice the instruction word at the same offsets.
package pipe_pkg;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_CTRL_W  = 4;
    localparam int DEF_REG_W   = 3;
    localparam int DEF_CONST_W = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_INS_W   = DEF_CTRL_W + 3 * DEF_REG_W + DEF_CONST_W;

    localparam logic [3:0] DEF_NOP_CTRL = 4'b1010;

    // LSB position of each field; ctrl sits at the top, const at the bottom
    localparam int OFF_CONST = 0;
    localparam int OFF_RD    = OFF_CONST + DEF_CONST_W;
    localparam int OFF_RS2   = OFF_RD + DEF_REG_W;
    localparam int OFF_RS1   = OFF_RS2 + DEF_REG_W;
    localparam int OFF_CTRL  = OFF_RS1 + DEF_REG_W;

    // Occupancy encoded as {head_v, skid_v}
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_TWO   = 2'b11
    } occ_e;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer: head entry drives the consumer, skid entry
// absorbs one accept while the head is blocked. Ready is a registered flop.
//
// state     | meaning
// OCC_EMPTY | no entry held, in_ready=1
// OCC_ONE   | head valid, skid empty, in_ready=1
// OCC_TWO   | head and skid valid, in_ready=0
module skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_PC_W + DEF_INS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              skid_valid
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              head_v, skid_v;
    logic              enq, deq;

    always_comb begin
        head_v     = (state_q != OCC_EMPTY);
        skid_v     = (state_q == OCC_TWO);
        enq        = in_valid & in_ready_q;
        deq        = head_v & out_ready & ~stall;
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (enq) begin
                        head_d  = in_data;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (enq && deq) begin
                        head_d = in_data;
                    end else if (enq) begin
                        skid_d  = in_data;
                        state_d = OCC_TWO;
                    end else if (deq) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so no accept can coincide
                    if (deq) begin
                        head_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = head_v;
    assign out_data   = head_q;
    assign skid_valid = skid_v;

endmodule

// File: rtl/if_id_elastic.sv
// IF/ID pipeline register: elastic skid buffer plus instruction field split,
// bubble presentation on an empty head, and a saturating squash counter.
module if_id_elastic
    import pipe_pkg::*;
#(
    parameter int                PC_W     = DEF_PC_W,
    parameter int                CTRL_W   = DEF_CTRL_W,
    parameter int                REG_W    = DEF_REG_W,
    parameter int                CONST_W  = DEF_CONST_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(DEF_NOP_CTRL),
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [CTRL_W+3*REG_W+CONST_W-1:0] in_ins,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [REG_W-1:0]     out_rs1,
    output logic [REG_W-1:0]     out_rs2,
    output logic [REG_W-1:0]     out_rd,
    output logic [CONST_W-1:0]   out_const,
    output logic [CNT_W-1:0]     squash_cnt
);

    localparam int INS_W   = CTRL_W + 3 * REG_W + CONST_W;
    localparam int DATA_W  = PC_W + INS_W;
    localparam int RD_LSB  = CONST_W;
    localparam int RS2_LSB = RD_LSB + REG_W;
    localparam int RS1_LSB = RS2_LSB + REG_W;

    logic              head_v, skid_v;
    logic [DATA_W-1:0] head_data;
    logic [INS_W-1:0]  head_ins;
    logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;
    logic [1:0]        squash_inc;
    logic [CNT_W:0]    squash_sum;

    skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_ins}),
        .stall     (stall),
        .flush     (flush),
        .out_valid (head_v),
        .out_ready (out_ready),
        .out_data  (head_data),
        .skid_valid(skid_v)
    );

    assign head_ins = head_data[INS_W-1:0];

    always_comb begin
        out_valid = head_v;
        out_pc    = '0;
        out_ctrl  = NOP_CTRL;
        out_rs1   = '0;
        out_rs2   = '0;
        out_rd    = '0;
        out_const = '0;
        if (head_v) begin
            out_pc    = head_data[DATA_W-1 -: PC_W];
            out_ctrl  = head_ins[INS_W-1 -: CTRL_W];
            out_rs1   = head_ins[RS1_LSB +: REG_W];
            out_rs2   = head_ins[RS2_LSB +: REG_W];
            out_rd    = head_ins[RD_LSB +: REG_W];
            out_const = head_ins[CONST_W-1:0];
        end
    end

    // Count only what was actually held when the flush hit; saturate at all-ones
    always_comb begin
        squash_inc   = {1'b0, head_v} + {1'b0, skid_v};
        squash_sum   = {1'b0, squash_cnt_q} + (CNT_W+1)'(squash_inc);
        squash_cnt_d = squash_cnt_q;
        if (flush) begin
            squash_cnt_d = squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            squash_cnt_q <= '0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_if_id_elastic.sv
// Directed bench for if_id_elastic with a 2-bit squash counter so saturation
// is reachable in a few flushes.
module tb_if_id_elastic;

    localparam int PC_W  = 8;
    localparam int INS_W = 21;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INS_W-1:0]  in_ins;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [3:0]        out_ctrl;
    logic [2:0]        out_rs1;
    logic [2:0]        out_rs2;
    logic [2:0]        out_rd;
    logic [7:0]        out_const;
    logic [CNT_W-1:0]  squash_cnt;

    int checks = 0;
    int errors = 0;

    if_id_elastic #(
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ins    (in_ins),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_rd    (out_rd),
        .out_const (out_const),
        .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " ctrl"},  32'(out_ctrl),  32'hA);
        check({tag, " regs"},  32'({out_rs1, out_rs2, out_rd}), 32'd0);
        check({tag, " const"}, 32'(out_const), 32'd0);
        check({tag, " pc"},    32'(out_pc),    32'd0);
        check({tag, " ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic push(input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_ins    = 21'h1A53C3;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_bubble("reset");
        check("reset cnt", 32'(squash_cnt), 32'd0);
        rst_n = 1'b1;

        // Full-throughput stream
        out_ready = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            push(PC_W'(p));
            check("stream valid", 32'(out_valid), 32'd1);
            check("stream pc",    32'(out_pc),    32'(p));
            check("stream fields", 32'({out_ctrl, out_rs1, out_rs2, out_rd, out_const}),
                  32'({4'hD, 3'h1, 3'h2, 3'h3, 8'hC3}));
            check("stream ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream drained", 32'(out_valid), 32'd0);

        // Backpressure: third word must wait at the input
        out_ready = 1'b0;
        push(8'd10);
        check("bp first ready", 32'(in_ready), 32'd1);
        push(8'd11);
        check("bp second ready", 32'(in_ready), 32'd0);
        check("bp head", 32'(out_pc), 32'd10);
        push(8'd12);
        check("bp held ready", 32'(in_ready), 32'd0);
        check("bp held head", 32'(out_pc), 32'd10);
        out_ready = 1'b1;
        step();
        check("bp drain 11", 32'(out_pc), 32'd11);
        check("bp ready back", 32'(in_ready), 32'd1);
        step();
        check("bp drain 12", 32'(out_pc), 32'd12);
        check("bp drain valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("bp empty", 32'(out_valid), 32'd0);

        // Stall at occupancy 2 freezes the head even with out_ready high
        out_ready = 1'b0;
        push(8'd20);
        push(8'd21);
        in_valid  = 1'b0;
        stall     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall pc",    32'(out_pc),    32'd20);
            check("stall ready", 32'(in_ready),  32'd0);
        end
        stall = 1'b0;
        step();
        check("unstall pc", 32'(out_pc), 32'd21);
        step();
        check("unstall empty", 32'(out_valid), 32'd0);

        // Flush with stall at occupancy 2; the presented word is dropped
        out_ready = 1'b0;
        push(8'd30);
        push(8'd31);
        in_pc = 8'd32;
        stall = 1'b1;
        flush = 1'b1;
        step();
        check_bubble("flush");
        check("flush cnt", 32'(squash_cnt), 32'd2);
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush dropped", 32'(out_valid), 32'd0);

        // Saturation of the 2-bit counter
        push(8'd40);
        push(8'd41);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        check("sat cnt 3", 32'(squash_cnt), 32'd3);
        flush = 1'b0;
        push(8'd50);
        push(8'd51);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        check("sat cnt hold", 32'(squash_cnt), 32'd3);
        flush = 1'b0;

        // Reset mid-stream at occupancy 1
        push(8'd60);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        check("pre-reset pc", 32'(out_pc), 32'd60);
        in_pc = 8'd61;
        rst_n = 1'b0;
        step();
        check_bubble("mid reset");
        check("mid reset cnt", 32'(squash_cnt), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        check("post reset empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
